sa_allocator: RTL and testbench

Separable switch allocator with per-output credit gating for the 5-port mesh router. It picks at most one VC per input port and at most one input port per output port each cycle. The winners are registered as the switch-traversal (ST) stage control: read enables, VC ids, input-select ids, output VC ids and look-ahead routing. These drive the crossbar directly.

---
 rtl/sa_allocator.sv | 198 +++++++++++++++++++
 tb/tb_sa_allocator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_allocator.sv
// sa_allocator: separable (input-first) switch allocator with per-output credit gating.
// Build option SA_XY_TURN_FILTER_EN: mask requests whose turn violates XY dimension order.
module sa_allocator #(
  parameter int unsigned INPUT_PORT_NUM  = 5,
  parameter int unsigned OUTPUT_PORT_NUM = 5,
  parameter int unsigned VC_NUM          = 4,
  parameter int unsigned VC_IDX_W        = 3,
  parameter int unsigned CREDIT_DEPTH    = 4,
  parameter int unsigned CREDIT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [INPUT_PORT_NUM*VC_NUM-1:0]               sa_req_vld_i,
  input  logic [INPUT_PORT_NUM*VC_NUM*VC_IDX_W-1:0]      sa_req_outport_i,
  input  logic [INPUT_PORT_NUM*VC_NUM*VC_IDX_W-1:0]      sa_req_out_vc_id_i,
  input  logic [INPUT_PORT_NUM*VC_NUM*VC_IDX_W-1:0]      sa_req_look_ahead_i,
  input  logic [OUTPUT_PORT_NUM-1:0]                     credit_return_i,
  output logic [INPUT_PORT_NUM*VC_NUM-1:0]               sa_grant_o,
  output logic [INPUT_PORT_NUM-1:0]                      inport_read_enable_st_stage_o,
  output logic [INPUT_PORT_NUM*VC_IDX_W-1:0]             inport_read_vc_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM-1:0]                     outport_vld_st_stage_o,
  output logic [OUTPUT_PORT_NUM*VC_IDX_W-1:0]            outport_select_inport_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM*VC_IDX_W-1:0]            outport_vc_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM*VC_IDX_W-1:0]            outport_look_ahead_routing_st_stage_o,
  output logic [OUTPUT_PORT_NUM*CREDIT_W-1:0]            credit_cnt_o
);

  localparam int unsigned NI = INPUT_PORT_NUM;
  localparam int unsigned NO = OUTPUT_PORT_NUM;
  localparam int unsigned NV = VC_NUM;
  localparam int unsigned W  = VC_IDX_W;
  localparam int unsigned CW = CREDIT_W;

  logic [NI-1:0][NV-1:0]         req_vld;
  logic [NI-1:0][NV-1:0][W-1:0]  req_op, req_ovc, req_la;
  logic [NI-1:0][NV-1:0]         elig;

  logic [NI-1:0]                 s1_vld, s1_hi_vld;
  logic [NI-1:0][W-1:0]          s1_hi_vc, s1_lo_vc, s1_vc, s1_op;
  logic [NO-1:0]                 s2_vld, s2_hi_vld;
  logic [NO-1:0][W-1:0]          s2_hi_in, s2_lo_in, s2_in;

  logic [NI-1:0][NV-1:0]         grant_d, grant_q;
  logic [NI-1:0]                 rd_en_d, rd_en_q;
  logic [NI-1:0][W-1:0]          rd_vc_d, rd_vc_q;
  logic [NO-1:0]                 out_vld_d, out_vld_q;
  logic [NO-1:0][W-1:0]          out_sel_d, out_sel_q;
  logic [NO-1:0][W-1:0]          out_vc_d, out_vc_q;
  logic [NO-1:0][W-1:0]          out_la_d, out_la_q;
  logic [NO-1:0][CW-1:0]         credit_d, credit_q;
  logic [NI-1:0][W-1:0]          in_ptr_d, in_ptr_q;
  logic [NO-1:0][W-1:0]          out_ptr_d, out_ptr_q;

  assign req_vld = sa_req_vld_i;
  assign req_op  = sa_req_outport_i;
  assign req_ovc = sa_req_out_vc_id_i;
  assign req_la  = sa_req_look_ahead_i;

  function automatic logic turn_ok(input int unsigned in_idx, input int unsigned out_idx);
`ifdef SA_XY_TURN_FILTER_EN
    if (out_idx == 2) return (in_idx == 3) || (in_idx == 4);
    if (out_idx == 3) return (in_idx == 2) || (in_idx == 4);
`endif
    return in_idx != out_idx;
  endfunction

  // Eligibility: in-range, non-U-turn (turn-filtered), downstream credit available
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NI; i++)
      for (int unsigned v = 0; v < NV; v++)
        for (int unsigned o = 0; o < NO; o++)
          if (req_vld[i][v] && req_op[i][v] == W'(o) && turn_ok(i, o) && credit_q[o] != '0)
            elig[i][v] = 1'b1;
  end

  // Stage 1: lowest eligible VC at/above the pointer, else lowest overall
  always_comb begin
    s1_vld    = '0;
    s1_hi_vld = '0;
    s1_hi_vc  = '0;
    s1_lo_vc  = '0;
    s1_vc     = '0;
    s1_op     = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      for (int v = int'(NV) - 1; v >= 0; v--) begin
        if (elig[i][v]) begin
          s1_vld[i]   = 1'b1;
          s1_lo_vc[i] = W'(v);
          if (W'(v) >= in_ptr_q[i]) begin
            s1_hi_vld[i] = 1'b1;
            s1_hi_vc[i]  = W'(v);
          end
        end
      end
      s1_vc[i] = s1_hi_vld[i] ? s1_hi_vc[i] : s1_lo_vc[i];
      for (int unsigned v = 0; v < NV; v++)
        if (s1_vc[i] == W'(v)) s1_op[i] = req_op[i][v];
    end
  end

  // Stage 2: same wrap-around priority among inputs whose candidate targets this output
  always_comb begin
    s2_vld    = '0;
    s2_hi_vld = '0;
    s2_hi_in  = '0;
    s2_lo_in  = '0;
    s2_in     = '0;
    for (int unsigned o = 0; o < NO; o++) begin
      for (int i = int'(NI) - 1; i >= 0; i--) begin
        if (s1_vld[i] && s1_op[i] == W'(o)) begin
          s2_vld[o]   = 1'b1;
          s2_lo_in[o] = W'(i);
          if (W'(i) >= out_ptr_q[o]) begin
            s2_hi_vld[o] = 1'b1;
            s2_hi_in[o]  = W'(i);
          end
        end
      end
      s2_in[o] = s2_hi_vld[o] ? s2_hi_in[o] : s2_lo_in[o];
    end
  end

  // ST-stage payload, pointer advance and credit bookkeeping
  always_comb begin
    grant_d   = '0;
    rd_en_d   = '0;
    rd_vc_d   = '0;
    out_vld_d = '0;
    out_sel_d = '0;
    out_vc_d  = '0;
    out_la_d  = '0;
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    credit_d  = credit_q;
    for (int unsigned o = 0; o < NO; o++) begin
      if (s2_vld[o]) begin
        out_vld_d[o] = 1'b1;
        out_sel_d[o] = s2_in[o];
        out_ptr_d[o] = (s2_in[o] == W'(NI - 1)) ? '0 : s2_in[o] + W'(1);
      end
    end
    for (int unsigned i = 0; i < NI; i++)
      for (int unsigned v = 0; v < NV; v++)
        for (int unsigned o = 0; o < NO; o++)
          if (s1_vld[i] && s1_vc[i] == W'(v) && s2_vld[o] && s2_in[o] == W'(i)) begin
            grant_d[i][v] = 1'b1;
            rd_en_d[i]    = 1'b1;
            rd_vc_d[i]    = W'(v);
            out_vc_d[o]   = req_ovc[i][v];
            out_la_d[o]   = req_la[i][v];
            in_ptr_d[i]   = (v == NV - 1) ? '0 : W'(v + 1);
          end
    for (int unsigned o = 0; o < NO; o++) begin
      case ({s2_vld[o], credit_return_i[o]})
        2'b10:   credit_d[o] = credit_q[o] - CW'(1);
        2'b01:   if (credit_q[o] != CW'(CREDIT_DEPTH)) credit_d[o] = credit_q[o] + CW'(1);
        default: credit_d[o] = credit_q[o];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      rd_en_q   <= '0;
      rd_vc_q   <= '0;
      out_vld_q <= '0;
      out_sel_q <= '0;
      out_vc_q  <= '0;
      out_la_q  <= '0;
      credit_q  <= {NO{CW'(CREDIT_DEPTH)}};
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
    end else begin
      grant_q   <= grant_d;
      rd_en_q   <= rd_en_d;
      rd_vc_q   <= rd_vc_d;
      out_vld_q <= out_vld_d;
      out_sel_q <= out_sel_d;
      out_vc_q  <= out_vc_d;
      out_la_q  <= out_la_d;
      credit_q  <= credit_d;
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
    end
  end

  assign sa_grant_o                            = grant_q;
  assign inport_read_enable_st_stage_o         = rd_en_q;
  assign inport_read_vc_id_st_stage_o          = rd_vc_q;
  assign outport_vld_st_stage_o                = out_vld_q;
  assign outport_select_inport_id_st_stage_o   = out_sel_q;
  assign outport_vc_id_st_stage_o              = out_vc_q;
  assign outport_look_ahead_routing_st_stage_o = out_la_q;
  assign credit_cnt_o                          = credit_q;

endmodule

// File: tb/tb_sa_allocator.sv
// tb_sa_allocator: vector table, directed corner sequences and random traffic against a
// cycle-level reference model of the allocator.
module tb_sa_allocator;
  localparam int NI = 5;
  localparam int NO = 5;
  localparam int NV = 4;
  localparam int W  = 3;
  localparam int CD = 4;
  localparam int CW = 3;
`ifdef SA_XY_TURN_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NI*NV-1:0]    req_vld;
  logic [NI*NV*W-1:0]  req_op, req_ovc, req_la;
  logic [NO-1:0]       cred_ret;
  logic [NI*NV-1:0]    sa_grant;
  logic [NI-1:0]       rd_en;
  logic [NI*W-1:0]     rd_vc;
  logic [NO-1:0]       o_vld;
  logic [NO*W-1:0]     o_sel, o_vcid, o_la;
  logic [NO*CW-1:0]    cred;

  always #5 clk = ~clk;

  sa_allocator #(
    .INPUT_PORT_NUM(NI), .OUTPUT_PORT_NUM(NO), .VC_NUM(NV), .VC_IDX_W(W),
    .CREDIT_DEPTH(CD), .CREDIT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .sa_req_vld_i(req_vld), .sa_req_outport_i(req_op),
    .sa_req_out_vc_id_i(req_ovc), .sa_req_look_ahead_i(req_la),
    .credit_return_i(cred_ret),
    .sa_grant_o(sa_grant),
    .inport_read_enable_st_stage_o(rd_en),
    .inport_read_vc_id_st_stage_o(rd_vc),
    .outport_vld_st_stage_o(o_vld),
    .outport_select_inport_id_st_stage_o(o_sel),
    .outport_vc_id_st_stage_o(o_vcid),
    .outport_look_ahead_routing_st_stage_o(o_la),
    .credit_cnt_o(cred)
  );

  int tests = 0;
  int fails = 0;

  // reference model state and predicted registered outputs
  int m_cred[NO];
  int m_inptr[NI];
  int m_outptr[NO];
  logic [NI*NV-1:0] e_grant;
  logic [NI-1:0]    e_rden;
  logic [NI*W-1:0]  e_rdvc;
  logic [NO-1:0]    e_ovld;
  logic [NO*W-1:0]  e_sel, e_vcid, e_la;
  logic [NO*CW-1:0] e_cred;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int fld(input logic [NI*NV*W-1:0] vec, input int i, input int v);
    return int'(vec[(i*NV+v)*W +: W]);
  endfunction

  function automatic bit turn_ok_m(input int i, input int o);
    if (FILT && o == 2) return (i == 3 || i == 4);
    if (FILT && o == 3) return (i == 2 || i == 4);
    return i != o;
  endfunction

  function automatic bit eligible(input int i, input int v);
    int op;
    op = fld(req_op, i, v);
    if (!req_vld[i*NV+v] || op >= NO) return 1'b0;
    if (!turn_ok_m(i, op)) return 1'b0;
    return m_cred[op] > 0;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin m_cred[o] = CD; m_outptr[o] = 0; end
    for (int i = 0; i < NI; i++) m_inptr[i] = 0;
    e_grant = '0; e_rden = '0; e_rdvc = '0; e_ovld = '0;
    e_sel = '0; e_vcid = '0; e_la = '0;
    for (int o = 0; o < NO; o++) e_cred[o*CW +: CW] = CW'(CD);
  endtask

  // One allocation cycle using the current stimulus; predicts next-cycle outputs
  task automatic model_cycle();
    bit cv[NI];
    int cvc[NI];
    int cop[NI];
    e_grant = '0; e_rden = '0; e_rdvc = '0; e_ovld = '0;
    e_sel = '0; e_vcid = '0; e_la = '0;
    for (int i = 0; i < NI; i++) begin
      cv[i] = 1'b0; cvc[i] = 0; cop[i] = 0;
      for (int k = 0; k < NV; k++) begin
        int v;
        v = (m_inptr[i] + k) % NV;
        if (!cv[i] && eligible(i, v)) begin
          cv[i] = 1'b1; cvc[i] = v; cop[i] = fld(req_op, i, v);
        end
      end
    end
    for (int o = 0; o < NO; o++) begin
      int win;
      win = -1;
      for (int k = 0; k < NI; k++) begin
        int i;
        i = (m_outptr[o] + k) % NI;
        if (win < 0 && cv[i] && cop[i] == o) win = i;
      end
      if (win >= 0) begin
        e_ovld[o] = 1'b1;
        e_sel[o*W +: W]  = W'(win);
        e_vcid[o*W +: W] = W'(fld(req_ovc, win, cvc[win]));
        e_la[o*W +: W]   = W'(fld(req_la, win, cvc[win]));
        e_rden[win] = 1'b1;
        e_rdvc[win*W +: W] = W'(cvc[win]);
        e_grant[win*NV + cvc[win]] = 1'b1;
        m_inptr[win] = (cvc[win] + 1) % NV;
        m_outptr[o]  = (win + 1) % NI;
      end
      if (win >= 0 && !cred_ret[o]) m_cred[o] = m_cred[o] - 1;
      else if (win < 0 && cred_ret[o] && m_cred[o] < CD) m_cred[o] = m_cred[o] + 1;
      e_cred[o*CW +: CW] = CW'(m_cred[o]);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, "_grant"}, 64'(sa_grant), 64'(e_grant));
    chk({t, "_rden"},  64'(rd_en),    64'(e_rden));
    chk({t, "_rdvc"},  64'(rd_vc),    64'(e_rdvc));
    chk({t, "_ovld"},  64'(o_vld),    64'(e_ovld));
    chk({t, "_sel"},   64'(o_sel),    64'(e_sel));
    chk({t, "_vcid"},  64'(o_vcid),   64'(e_vcid));
    chk({t, "_la"},    64'(o_la),     64'(e_la));
    chk({t, "_cred"},  64'(cred),     64'(e_cred));
  endtask

  task automatic clear_req();
    req_vld = '0; req_op = '0; req_ovc = '0; req_la = '0; cred_ret = '0;
  endtask

  task automatic set_req(input int i, input int v, input int op, input int ovc, input int la);
    req_vld[i*NV+v] = 1'b1;
    req_op[(i*NV+v)*W +: W]  = W'(op);
    req_ovc[(i*NV+v)*W +: W] = W'(ovc);
    req_la[(i*NV+v)*W +: W]  = W'(la);
  endtask

  task automatic step(input string t);
    model_cycle();
    @(posedge clk);
    #1;
    check_all(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    int in_p; int vc; int op; int ovc; int la; bit vld; int cred;
  } vec_t;

  vec_t vecs[9];
  int   exp_sel_seq[6] = '{0, 2, 4, 0, 2, 4};
  int   exp_rdvc_seq[3] = '{0, 3, 0};
  int   ex_ret[13]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
  int   ex_vld[13]  = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0};
  int   ex_cred[13] = '{3, 2, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    vecs[0] = '{1, 2, 0, 1, 3, 1'b1, 3};
    vecs[1] = '{0, 0, 0, 2, 2, 1'b0, 4};
    vecs[2] = '{4, 3, 4, 1, 1, 1'b0, 4};
    vecs[3] = '{2, 1, 7, 0, 0, 1'b0, -1};
    vecs[4] = '{0, 0, 2, 3, 1, !FILT, FILT ? 4 : 3};
    vecs[5] = '{3, 3, 2, 2, 4, 1'b1, 3};
    vecs[6] = '{4, 0, 3, 1, 2, 1'b1, 3};
    vecs[7] = '{2, 1, 1, 2, 4, 1'b1, 3};
    vecs[8] = '{1, 0, 3, 5, 6, !FILT, FILT ? 4 : 3};

    clear_req();
    do_reset();
    step("idle0");
    cred_ret = '1;
    step("sat_ret");
    chk("sat_cred0", 64'(cred[0 +: CW]), 64'(CD));
    cred_ret = '0;
    step("idle1");

    // single-request vectors, each from reset
    foreach (vecs[n]) begin
      do_reset();
      set_req(vecs[n].in_p, vecs[n].vc, vecs[n].op, vecs[n].ovc, vecs[n].la);
      step("vec");
      if (vecs[n].vld) begin
        chk("vec_ovld",  64'(o_vld[vecs[n].op]), 64'(1));
        chk("vec_sel",   64'(o_sel[vecs[n].op*W +: W]), 64'(vecs[n].in_p));
        chk("vec_vcid",  64'(o_vcid[vecs[n].op*W +: W]), 64'(vecs[n].ovc));
        chk("vec_la",    64'(o_la[vecs[n].op*W +: W]), 64'(vecs[n].la));
        chk("vec_rden",  64'(rd_en[vecs[n].in_p]), 64'(1));
        chk("vec_rdvc",  64'(rd_vc[vecs[n].in_p*W +: W]), 64'(vecs[n].vc));
      end else begin
        chk("vec_noovld", 64'(o_vld), 64'(0));
        chk("vec_nogrant", 64'(sa_grant), 64'(0));
      end
      if (vecs[n].cred >= 0)
        chk("vec_cred", 64'(cred[vecs[n].op*CW +: CW]), 64'(vecs[n].cred));
    end

    // asynchronous reset mid-operation clears outputs before any clock edge
    do_reset();
    set_req(1, 2, 0, 1, 3);
    step("pre_arst");
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ovld", 64'(o_vld), 64'(0));
    chk("arst_grant", 64'(sa_grant), 64'(0));
    chk("arst_rden", 64'(rd_en), 64'(0));
    chk("arst_cred", 64'(cred), {49'b0, {NO{3'(CD)}}});
    clear_req();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // N, E, L contend for S; returns keep credits topped up
    do_reset();
    set_req(0, 0, 1, 1, 1);
    set_req(2, 0, 1, 2, 2);
    set_req(4, 0, 1, 3, 3);
    cred_ret[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step("cont");
      chk("cont_vld", 64'(o_vld[1]), 64'(1));
      chk("cont_sel", 64'(o_sel[W +: W]), 64'(exp_sel_seq[c]));
      chk("cont_cred", 64'(cred[CW +: CW]), 64'(CD));
    end

    // L -> N credit exhaustion, single-return regrant, coincident return+grant
    do_reset();
    set_req(4, 0, 0, 0, 0);
    for (int c = 0; c < 13; c++) begin
      cred_ret[0] = ex_ret[c][0];
      step("cred");
      chk("cred_vld", 64'(o_vld[0]), 64'(ex_vld[c]));
      chk("cred_cnt", 64'(cred[0 +: CW]), 64'(ex_cred[c]));
    end

    // W vc0 and vc3 both request N
    do_reset();
    set_req(3, 0, 0, 1, 1);
    set_req(3, 3, 0, 2, 2);
    cred_ret[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("vcrr");
      chk("vcrr_rdvc", 64'(rd_vc[3*W +: W]), 64'(exp_rdvc_seq[c]));
    end

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NI*NV; b++) begin
        req_vld[b] = ($urandom_range(0, 99) < 40);
        req_op[b*W +: W]  = W'($urandom_range(0, 6));
        req_ovc[b*W +: W] = W'($urandom_range(0, 7));
        req_la[b*W +: W]  = W'($urandom_range(0, 7));
      end
      for (int o = 0; o < NO; o++) cred_ret[o] = ($urandom_range(0, 99) < 35);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
